// File: rtl/tcas_pkg.sv
// Shared TCAS encodings, advisory classes, annunciator states and aural message codes.
package tcas_pkg;
  localparam logic [2:0] TRF_RESET    = 3'b000;
  localparam logic [2:0] TRF_NONE     = 3'b001;
  localparam logic [2:0] TRF_ADVISORY = 3'b010;

  localparam logic [2:0] RES_RESET    = 3'b000;
  localparam logic [2:0] RES_NONE     = 3'b001;
  localparam logic [2:0] RES_DESCEND  = 3'b010;
  localparam logic [2:0] RES_CLIMB    = 3'b011;

  typedef enum logic [2:0] {
    CLS_INOP, CLS_CLEAR, CLS_TA, CLS_RA_UP, CLS_RA_DN
  } cls_e;

  typedef enum logic [2:0] {
    ST_INOP, ST_CLEAR, ST_TA, ST_RA_UP, ST_RA_DN, ST_COC
  } state_e;

  typedef enum logic [2:0] {
    MSG_NONE        = 3'd0,
    MSG_TRAFFIC     = 3'd1,
    MSG_CLIMB       = 3'd2,
    MSG_DESCEND     = 3'd3,
    MSG_CLIMB_NOW   = 3'd4,
    MSG_DESCEND_NOW = 3'd5,
    MSG_CLEAR       = 3'd6
  } msg_e;

  typedef struct packed {
    logic vld;
    msg_e msg;
  } voice_slot_t;

  // Unlisted traffic/resolution codes fall through to CLEAR.
  function automatic cls_e derive_cls(input logic [2:0] trf, input logic [2:0] res);
    if (trf == TRF_RESET || res == RES_RESET) return CLS_INOP;
    if (res == RES_CLIMB)                     return CLS_RA_UP;
    if (res == RES_DESCEND)                   return CLS_RA_DN;
    if (trf == TRF_ADVISORY)                  return CLS_TA;
    return CLS_CLEAR;
  endfunction
endpackage

// File: rtl/tcas_persist_filter.sv
// Accepts an advisory class once it has been sampled on PERSIST consecutive edges.
module tcas_persist_filter
  import tcas_pkg::*;
#(
  parameter int PERSIST = 4,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_cls,
  output logic [2:0] o_acc,
  output logic       o_evt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] P_LAST  = CNT_W'(PERSIST);

  logic [2:0]       r_cand, r_acc;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_hit;

  // The edge that samples a new class counts as its first.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_cls != r_cand)     w_cnt_nxt = CNT_W'(1);
    else if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + CNT_W'(1);
    w_hit = (w_cnt_nxt == P_LAST) && (i_cls != r_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand <= CLS_INOP;
      r_cnt  <= '0;
      r_acc  <= CLS_INOP;
    end else begin
      r_cand <= i_cls;
      r_cnt  <= w_cnt_nxt;
      if (w_hit) r_acc <= i_cls;
    end
  end

  assign o_acc = r_acc;
  assign o_evt = w_hit;
endmodule

// File: rtl/tcas_annunciator.sv
// TCAS cockpit annunciator: persistence-filtered advisory FSM, lamps and aural sequencing.
// Build option: AURAL_REPEAT_EN re-requests the RA aural every REPEAT_CYC cycles in an RA state.
module tcas_annunciator
  import tcas_pkg::*;
#(
  parameter int PERSIST    = 4,
  parameter int COC_HOLD   = 16,
  parameter int REPEAT_CYC = 64,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] tcas_traffic,
  input  logic [2:0] tcas_resolution,
  input  logic       voice_ack,
  output logic       voice_req,
  output logic [2:0] voice_msg,
  output logic       msg_overrun,
  output logic       inop_lamp,
  output logic       amber_lamp,
  output logic       red_lamp,
  output logic       arrow_up,
  output logic       arrow_down
);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(COC_HOLD - 1);

  if (PERSIST < 1 || PERSIST > (2**CNT_W - 1) || COC_HOLD < 1 || REPEAT_CYC < 1) begin : g_bad_cfg
    $error("tcas_annunciator: parameter out of range");
  end

  logic [2:0]       w_cls, w_acc;
  logic             w_evt;
  state_e           r_state, w_nxt;
  logic [CNT_W-1:0] r_hold;
  logic             w_msg_vld, w_inop_entry, w_rep_fire, w_done;
  msg_e             w_msg;
  logic             r_req, r_ovr;
  msg_e             r_msg;
  voice_slot_t      r_pend;
  logic [4:0]       r_lamps;

  assign w_cls = derive_cls(tcas_traffic, tcas_resolution);

  tcas_persist_filter #(.PERSIST(PERSIST), .CNT_W(CNT_W)) u_filt (
    .clk   (clk),
    .rst   (rst),
    .i_cls (w_cls),
    .o_acc (w_acc),
    .o_evt (w_evt)
  );

  always_comb begin
    w_nxt        = r_state;
    w_msg_vld    = 1'b0;
    w_msg        = MSG_NONE;
    w_inop_entry = 1'b0;
    if (w_evt) begin
      case (w_cls)
        CLS_INOP: begin
          w_nxt        = ST_INOP;
          w_inop_entry = 1'b1;
        end
        CLS_RA_UP: begin
          w_nxt     = ST_RA_UP;
          w_msg_vld = 1'b1;
          w_msg     = (r_state == ST_RA_DN) ? MSG_CLIMB_NOW : MSG_CLIMB;
        end
        CLS_RA_DN: begin
          w_nxt     = ST_RA_DN;
          w_msg_vld = 1'b1;
          w_msg     = (r_state == ST_RA_UP) ? MSG_DESCEND_NOW : MSG_DESCEND;
        end
        default: begin
          case (r_state)
            ST_RA_UP, ST_RA_DN: begin
              w_nxt     = ST_COC;
              w_msg_vld = 1'b1;
              w_msg     = MSG_CLEAR;
            end
            // TA/CLEAR inside COC only retargets where the hold expiry lands.
            ST_COC: if (r_hold == HOLD_LAST)
              w_nxt = (w_cls == CLS_TA) ? ST_TA : ST_CLEAR;
            default: begin
              if (w_cls == CLS_TA) begin
                w_nxt     = ST_TA;
                w_msg_vld = (r_state != ST_TA);
                w_msg     = MSG_TRAFFIC;
              end else begin
                w_nxt = ST_CLEAR;
              end
            end
          endcase
        end
      endcase
    end else if (r_state == ST_COC && r_hold == HOLD_LAST) begin
      w_nxt = (w_acc == CLS_TA) ? ST_TA : ST_CLEAR;
    end else if (w_rep_fire) begin
      w_msg_vld = 1'b1;
      w_msg     = (r_state == ST_RA_UP) ? MSG_CLIMB : MSG_DESCEND;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INOP;
      r_hold  <= '0;
      r_lamps <= 5'b10000;
    end else begin
      r_state <= w_nxt;
      if (w_nxt == ST_COC && r_state != ST_COC) r_hold <= '0;
      else if (r_state == ST_COC && r_hold != CNT_MAX) r_hold <= r_hold + CNT_W'(1);
      r_lamps <= {w_nxt == ST_INOP, w_nxt == ST_TA,
                  w_nxt == ST_RA_UP || w_nxt == ST_RA_DN,
                  w_nxt == ST_RA_UP, w_nxt == ST_RA_DN};
    end
  end

`ifdef AURAL_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);
  logic [CNT_W-1:0] r_rep;

  assign w_rep_fire = (r_state == ST_RA_UP || r_state == ST_RA_DN) && r_rep == REP_LAST;

  always_ff @(posedge clk) begin
    if (rst)                               r_rep <= '0;
    else if (w_nxt != r_state || w_rep_fire) r_rep <= '0;
    else if (r_rep != CNT_MAX)             r_rep <= r_rep + CNT_W'(1);
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  assign w_done = r_req & voice_ack;

  // A message emitted on a completing edge goes straight out; the pending entry waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req  <= 1'b0;
      r_msg  <= MSG_NONE;
      r_pend <= '0;
      r_ovr  <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_inop_entry) r_pend.vld <= 1'b0;
      if (w_msg_vld) begin
        if (!r_req || w_done) begin
          r_req <= 1'b1;
          r_msg <= w_msg;
        end else begin
          r_pend <= '{vld: 1'b1, msg: w_msg};
          r_ovr  <= r_pend.vld;
        end
      end else if (w_done) begin
        if (r_pend.vld && !w_inop_entry) begin
          r_msg      <= r_pend.msg;
          r_pend.vld <= 1'b0;
        end else begin
          r_req <= 1'b0;
          r_msg <= MSG_NONE;
        end
      end
    end
  end

  assign voice_req   = r_req;
  assign voice_msg   = r_msg;
  assign msg_overrun = r_ovr;
  assign {inop_lamp, amber_lamp, red_lamp, arrow_up, arrow_down} = r_lamps;
endmodule

// File: tb/tb_tcas_annunciator.sv
// Directed bench for tcas_annunciator (default build, PERSIST=4, COC_HOLD=16).
module tb_tcas_annunciator;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] trf, res;
  logic       ack;
  logic       voice_req, msg_overrun;
  logic [2:0] voice_msg;
  logic       inop_lamp, amber_lamp, red_lamp, arrow_up, arrow_down;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [4:0] L_INOP = 5'b10000;
  localparam logic [4:0] L_TA   = 5'b01000;
  localparam logic [4:0] L_UP   = 5'b00110;
  localparam logic [4:0] L_DN   = 5'b00101;
  localparam logic [4:0] L_OFF  = 5'b00000;

  tcas_annunciator #(.PERSIST(4), .COC_HOLD(16), .REPEAT_CYC(64), .CNT_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .tcas_traffic    (trf),
    .tcas_resolution (res),
    .voice_ack       (ack),
    .voice_req       (voice_req),
    .voice_msg       (voice_msg),
    .msg_overrun     (msg_overrun),
    .inop_lamp       (inop_lamp),
    .amber_lamp      (amber_lamp),
    .red_lamp        (red_lamp),
    .arrow_up        (arrow_up),
    .arrow_down      (arrow_down)
  );

  always #5 clk = ~clk;

  wire [4:0] w_lamps = {inop_lamp, amber_lamp, red_lamp, arrow_up, arrow_down};
  wire [3:0] w_voice = {voice_req, voice_msg};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] v(input logic req, input logic [2:0] msg);
    return {req, msg};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; trf = 3'b001; res = 3'b001; ack = 1'b0;
    tick(1);
    chk("rst_lamps", w_lamps, L_INOP);
    chk("rst_voice", w_voice, 0);
    chk("rst_ovr",   msg_overrun, 0);
    rst = 1'b0;

    tick(3); chk("clr_pre",   w_lamps, L_INOP);
    tick(1); chk("clr_acc",   w_lamps, L_OFF);
             chk("clr_voice", w_voice, 0);

    trf = 3'b010; ack = 1'b1;
    tick(3); chk("ta_pre",  w_lamps, L_OFF);
    tick(1); chk("ta_acc",  w_lamps, L_TA);
             chk("ta_msg",  w_voice, v(1, 1));
    tick(1); chk("ta_done", w_voice, 0);

    res = 3'b011; tick(3); chk("glitch_pre",  w_lamps, L_TA);
    res = 3'b001; tick(1);
    res = 3'b011; tick(3); chk("glitch_hold", w_lamps, L_TA);
    tick(1); chk("raup_acc",  w_lamps, L_UP);
             chk("raup_msg",  w_voice, v(1, 2));
    tick(1); chk("raup_done", w_voice, 0);

    ack = 1'b0; res = 3'b010;
    tick(4); chk("rev_acc",  w_lamps, L_DN);
             chk("rev_msg",  w_voice, v(1, 5));
    tick(2); chk("rev_hold", w_voice, v(1, 5));
    trf = 3'b001; res = 3'b001;
    tick(4); chk("coc1_lamps", w_lamps, L_OFF);
             chk("coc1_voice", w_voice, v(1, 5));
             chk("coc1_ovr",   msg_overrun, 0);
    res = 3'b011;
    tick(4); chk("ovr_lamps", w_lamps, L_UP);
             chk("ovr_pulse", msg_overrun, 1);
             chk("ovr_voice", w_voice, v(1, 5));
    tick(1); chk("ovr_clr",   msg_overrun, 0);
    ack = 1'b1;
    tick(1); chk("pend_dlv",   w_voice, v(1, 2));
    tick(1); chk("pend_empty", w_voice, 0);

    trf = 3'b010; res = 3'b001;
    tick(4);  chk("coc2_lamps", w_lamps, L_OFF);
              chk("coc2_msg",   w_voice, v(1, 6));
    tick(1);  chk("coc2_done",  w_voice, 0);
    tick(14); chk("coc2_hold",  w_lamps, L_OFF);
    tick(1);  chk("coc2_exit",  w_lamps, L_TA);
              chk("coc2_quiet", w_voice, 0);

    res = 3'b010;
    tick(4); chk("radn_acc",  w_lamps, L_DN);
             chk("radn_msg",  w_voice, v(1, 3));
    tick(1); chk("radn_done", w_voice, 0);
    trf = 3'b001; res = 3'b001;
    tick(4); chk("coc3_lamps", w_lamps, L_OFF);
             chk("coc3_msg",   w_voice, v(1, 6));
    tick(1); chk("coc3_done",  w_voice, 0);
    res = 3'b010;
    tick(3); chk("coc3_hold",  w_lamps, L_OFF);
    tick(1); chk("coc3_exit",  w_lamps, L_DN);
             chk("coc3_radn",  w_voice, v(1, 3));
    tick(1); chk("coc3_end",   w_voice, 0);

    ack = 1'b0; res = 3'b011;
    tick(4); chk("inop_up",    w_lamps, L_UP);
             chk("inop_cnow",  w_voice, v(1, 4));
    res = 3'b010;
    tick(4); chk("inop_dn",    w_lamps, L_DN);
             chk("inop_q",     w_voice, v(1, 4));
             chk("inop_novr",  msg_overrun, 0);
    res = 3'b000;
    tick(4); chk("inop_acc",   w_lamps, L_INOP);
             chk("inop_out",   w_voice, v(1, 4));
    tick(1); chk("inop_held",  w_voice, v(1, 4));
    ack = 1'b1;
    tick(1); chk("inop_flush", w_voice, 0);

    ack = 1'b0; trf = 3'b010; res = 3'b001;
    tick(4); chk("mid_ta",    w_lamps, L_TA);
             chk("mid_req",   w_voice, v(1, 1));
    rst = 1'b1;
    tick(1); chk("mid_rst_l", w_lamps, L_INOP);
             chk("mid_rst_v", w_voice, 0);
             chk("mid_rst_o", msg_overrun, 0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
